// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides and a
// multi-cycle shift-add multiplier; sits between decode and writeback.
module alu_seq_param #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] z_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_AND    = 5'b00001;
  localparam logic [4:0] OP_PASSA  = 5'b00010;
  localparam logic [4:0] OP_PASSB  = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b01100;
  localparam logic [4:0] OP_INC    = 5'b10100;
  localparam logic [4:0] OP_PASSA2 = 5'b10000;
  localparam logic [4:0] OP_ADDC   = 5'b00100;
  localparam logic [4:0] OP_SUBD   = 5'b01000;
  localparam logic [4:0] OP_OR     = 5'b00101;
  localparam logic [4:0] OP_XOR    = 5'b00110;
  localparam logic [4:0] OP_SHL    = 5'b00111;
  localparam logic [4:0] OP_SHR    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b11000;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_z_hi;
  logic             r_cout;
  logic             r_zero;
  logic             r_neg;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shr;
  logic [SW-1:0]    w_sh;
  logic             w_take;
  logic             w_is_mul;
  logic [PW-1:0]    w_acc_next;
  logic             w_last;

  assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_take    = in_valid && in_ready;
  assign w_is_mul  = MUL_EN && (sel == OP_MUL);
  assign w_sh      = b[SW-1:0];
  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign z_hi      = r_z_hi;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign neg       = r_neg;

  // Single-cycle datapath: bit WIDTH carries the carry/borrow or last bit shifted out.
  always_comb begin
    w_sum = '0;
    w_shr = '0;
    unique case (sel)
      OP_ADD:             w_sum = {1'b0, a} + {1'b0, b};
      OP_AND:             w_sum = {1'b0, a & b};
      OP_PASSA, OP_PASSA2: w_sum = {1'b0, a};
      OP_PASSB:           w_sum = {1'b0, b};
      OP_SUB:             w_sum = {1'b0, a} - {1'b0, b};
      OP_INC:             w_sum = {1'b0, a} + (WIDTH+1)'(1);
      OP_ADDC:            w_sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(1);
      OP_SUBD:            w_sum = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(1);
      OP_OR:              w_sum = {1'b0, a | b};
      OP_XOR:             w_sum = {1'b0, a ^ b};
      OP_SHL:             w_sum = {1'b0, a} << w_sh;
      OP_SHR: begin
        w_shr = {a, 1'b0} >> w_sh;
        w_sum = {w_shr[0], w_shr[WIDTH:1]};
      end
      default:            w_sum = '0;
    endcase
  end

  // One shift-add iteration; the WIDTH-th iteration's sum is the final product.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_z_hi      <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_take && w_is_mul) begin
            r_state     <= ST_BUSY;
            r_mcand     <= PW'(a);
            r_mplier    <= b;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
          end else if (w_take) begin
            r_z         <= w_sum[WIDTH-1:0];
            r_z_hi      <= '0;
            r_cout      <= w_sum[WIDTH];
            r_zero      <= (w_sum[WIDTH-1:0] == '0);
            r_neg       <= w_sum[WIDTH-1];
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state     <= ST_IDLE;
            r_z         <= w_acc_next[WIDTH-1:0];
            r_z_hi      <= w_acc_next[PW-1:WIDTH];
            r_cout      <= 1'b0;
            r_zero      <= (w_acc_next == '0);
            r_neg       <= w_acc_next[PW-1];
            r_out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param at WIDTH=8 with inline scenario checks.
module tb_alu_seq_param;

  typedef struct packed {
    logic [7:0] z;
    logic [7:0] z_hi;
    logic       cout;
    logic       zero;
    logic       neg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [4:0] sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] z;
  logic [7:0] z_hi;
  logic       cout;
  logic       zero;
  logic       neg;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  exp_t sb[$];
  exp_t m_e;

  alu_seq_param #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_hi(z_hi), .cout(cout), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model written with plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib, input logic [4:0] isel);
    exp_t e;
    int   ai;
    int   bi;
    int   r;
    int   sh;
    bit   defined;
    ai = int'(ia);
    bi = int'(ib);
    sh = bi % 8;
    r = 0;
    defined = 1'b1;
    e = '0;
    case (isel)
      5'd0:        r = ai + bi;
      5'd1:        r = ai & bi;
      5'd2, 5'd16: r = ai;
      5'd3:        r = bi;
      5'd12:       r = ai - bi;
      5'd20:       r = ai + 1;
      5'd4:        r = ai + bi + 1;
      5'd8:        r = ai - bi - 1;
      5'd5:        r = ai | bi;
      5'd6:        r = ai ^ bi;
      5'd7:        r = ai << sh;
      5'd9:        r = ai >> sh;
      5'd24:       r = ai * bi;
      default:     defined = 1'b0;
    endcase
    if (!defined) begin
      e.zero = 1'b1;
    end else if (isel == 5'd24) begin
      e.z    = 8'(r & 255);
      e.z_hi = 8'((r >> 8) & 255);
      e.zero = (r == 0);
      e.neg  = e.z_hi[7];
    end else begin
      e.z    = 8'(r & 255);
      if (isel == 5'd9) e.cout = (sh != 0) ? 1'((ai >> (sh - 1)) & 1) : 1'b0;
      else              e.cout = 1'((r >> 8) & 1);
      e.zero = (e.z == 8'h00);
      e.neg  = e.z[7];
    end
    return e;
  endfunction

  // Scoreboard: every result handed over on an out_valid && out_ready edge is compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: result z=%h z_hi=%h with no expected entry", z, z_hi);
      end else begin
        m_e = sb.pop_front();
        if ({z, z_hi, cout, zero, neg} !== m_e)
          $display("FAIL sb_result: got z=%h z_hi=%h cout=%b zero=%b neg=%b, expected z=%h z_hi=%h cout=%b zero=%b neg=%b",
                   z, z_hi, cout, zero, neg, m_e.z, m_e.z_hi, m_e.cout, m_e.zero, m_e.neg);
        else
          n_pass++;
      end
    end
  end

  // Drive one operation and return #1 after the accept edge (bounded wait).
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [4:0] isel, input bit push);
    int waited;
    waited = 0;
    a = ia; b = ib; sel = isel; in_valid = 1'b1;
    if (push) sb.push_back(model(ia, ib, isel));
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 60);
    if (!in_ready) begin
      n_total++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      if (push) sb.delete(sb.size() - 1);
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
    n_total++;
    if ({z, z_hi} !== 16'h0000) $display("FAIL reset_z: got %h required 0000", {z, z_hi}); else n_pass++;
    n_total++;
    if ({cout, zero, neg} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {cout, zero, neg}); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    issue(8'hF0, 8'h20, 5'b00000, 1'b1);
    n_total++;
    if ({out_valid, z, cout, zero, neg} !== {1'b1, 8'h10, 1'b1, 1'b0, 1'b0})
      $display("FAIL add_f0_20: got ov=%b z=%h c=%b zr=%b n=%b required ov=1 z=10 c=1 zr=0 n=0", out_valid, z, cout, zero, neg);
    else n_pass++;
    issue(8'h05, 8'h07, 5'b01100, 1'b1);
    n_total++;
    if ({z, cout, neg} !== {8'hFE, 1'b1, 1'b1})
      $display("FAIL sub_5_7: got z=%h c=%b n=%b required z=fe c=1 n=1", z, cout, neg);
    else n_pass++;
    issue(8'h07, 8'h06, 5'b01000, 1'b1);
    n_total++;
    if ({z, cout, zero} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL subdec_7_6: got z=%h c=%b zr=%b required z=00 c=0 zr=1", z, cout, zero);
    else n_pass++;
  endtask

  task automatic test_mul();
    issue(8'hFF, 8'hFF, 5'b11000, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      n_total++;
      if ({in_ready, out_valid} !== 2'b00)
        $display("FAIL mul_busy_%0d: got in_ready=%b out_valid=%b required 0 0", k, in_ready, out_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if ({out_valid, z_hi, z, cout, neg} !== {1'b1, 16'hFE01, 1'b0, 1'b1})
      $display("FAIL mul_ff_ff: got ov=%b prod=%h c=%b n=%b required ov=1 prod=fe01 c=0 n=1", out_valid, {z_hi, z}, cout, neg);
    else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL mul_done_ready: got %b required 1", in_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int start;
    logic [4:0] ops [4];
    ops[0] = 5'd0; ops[1] = 5'd5; ops[2] = 5'd6; ops[3] = 5'd12;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(8'h0F, 8'hF0, 5'b00101, 1'b1);
    a = 8'h01; b = 8'h02; sel = 5'b00000; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++;
      if ({in_ready, out_valid, z} !== {1'b0, 1'b1, 8'hFF})
        $display("FAIL backpressure_%0d: got in_ready=%b ov=%b z=%h required 0 1 ff", k, in_ready, out_valid, z);
      else n_pass++;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    start = cyc;
    issue(8'h01, 8'h02, 5'b00000, 1'b1);
    for (int k = 0; k < 4; k++)
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), ops[k], 1'b1);
    n_total++;
    if (cyc - start !== 5) $display("FAIL throughput: got %0d cycles for 5 ops required 5", cyc - start);
    else n_pass++;
  endtask

  task automatic test_shift();
    issue(8'h81, 8'h01, 5'b00111, 1'b1);
    n_total++;
    if ({z, cout} !== {8'h02, 1'b1}) $display("FAIL shl_81_1: got z=%h c=%b required 02 1", z, cout); else n_pass++;
    issue(8'h01, 8'h03, 5'b01001, 1'b1);
    n_total++;
    if ({z, cout, zero} !== {8'h00, 1'b0, 1'b1}) $display("FAIL shr_01_3: got z=%h c=%b zr=%b required 00 0 1", z, cout, zero); else n_pass++;
    issue(8'h80, 8'h08, 5'b00111, 1'b1);
    n_total++;
    if ({z, cout} !== {8'h80, 1'b0}) $display("FAIL shl_by0: got z=%h c=%b required 80 0", z, cout); else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    issue(8'h12, 8'h34, 5'b00000, 1'b1);
    issue(8'hFF, 8'hFF, 5'b11000, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({out_valid, in_ready, z, z_hi, cout, zero, neg} !== {1'b1 ^ 1'b1, 1'b1, 16'h0000, 3'b000})
      $display("FAIL reset_mid_mul: got ov=%b rdy=%b z=%h z_hi=%h flags=%b required 0 1 00 00 000",
               out_valid, in_ready, z, z_hi, {cout, zero, neg});
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_undefined();
    issue(8'hAA, 8'h55, 5'b11111, 1'b1);
    n_total++;
    if ({out_valid, z, z_hi, cout, zero, neg} !== {1'b1, 16'h0000, 3'b010})
      $display("FAIL undef_11111: got ov=%b z=%h z_hi=%h flags=%b required 1 00 00 010", out_valid, z, z_hi, {cout, zero, neg});
    else n_pass++;
    issue(8'hFF, 8'h01, 5'b01010, 1'b1);
    n_total++;
    if ({z, cout, zero} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL undef_01010: got z=%h c=%b zr=%b required 00 0 1", z, cout, zero);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)), 1'b1);
  endtask

  task automatic test_drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_shift();
    test_reset_mid_mul();
    test_undefined();
    test_random();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Registered, parametrised successor to the 8-bit combinational ALU. It keeps that ALU's 5-bit opcode map and carry semantics, and generalises the datapath to WIDTH bits. It adds valid/ready handshakes on both sides, registered status flags, new logic/shift opcodes, and a multi-cycle shift-add multiplier. It sits between the decode stage and the register-file writeback.

Parameters:
WIDTH, 8, datapath width in bits (>=4).
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as undefined opcode.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  5  opcode
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer accepts the result
z  output  WIDTH  result (low half for MUL)
z_hi  output  WIDTH  high half for MUL; 0 for all other ops
cout  output  1  carry/borrow
zero  output  1  z==0 (and z_hi==0 for MUL)
neg  output  1  MSB of z (MSB of z_hi for MUL)

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; out_valid=0; z, z_hi, cout, zero, neg = 0; multiplier counter cleared. Reset overrides everything, including an in-flight MUL.
- Accept: the operation is taken on an edge where in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Throughput is 1 op/cycle for single-cycle ops under continuous out_ready.
- Result hold: the result is dropped on an edge where out_valid && out_ready and no new result is loaded; out_valid then clears.
- Stability: while out_valid && !out_ready, z/z_hi/flags are held stable.
- Arithmetic rule: compute at WIDTH+1 bits; cout = bit WIDTH of the result, which is the borrow for subtracts (e.g. 5-7 gives cout=1).
- Single-cycle opcodes (result registered at the accept edge, latency 1):
  00000 A+B
  00001 A&B (cout=0)
  00010 A (cout=0)
  00011 B (cout=0)
  01100 A-B
  10100 A+1
  10000 A (cout=0)
  00100 A+B+1
  01000 A-B-1
- New opcodes:
  00101 A|B
  00110 A^B
  00111 A<<b[log2(WIDTH)-1:0]; cout = last bit shifted out, 0 for shift 0
  01001 A>>b[log2(WIDTH)-1:0] logical; same cout rule
- Undefined opcodes: z=0, z_hi=0, cout=0, zero=1, neg=0, out_valid=1 at latency 1. Never leave cout unassigned.
- MUL (11000, MUL_EN=1): unsigned shift-add multiply.
  - Accept edge: IDLE->BUSY; capture a, b; clear accumulator; counter=0.
  - Each BUSY edge: one iteration; counter++.
  - After WIDTH iterations: BUSY->IDLE; load {z_hi,z} = 2*WIDTH-bit product; cout=0; out_valid=1.
  - Latency: out_valid rises on the WIDTH-th edge after the accept edge.
  - in_ready=0 throughout BUSY.
  - out_ready is ignored during BUSY; any prior result is consumed or dropped before MUL can be accepted, per the in_ready rule.
- Flags are computed from the loaded result, in the same cycle it is loaded.
- Inputs a/b/sel are don't-care when not accepted and after capture.

Test Plan:
1. WIDTH=8, out_ready=1, add a=8'hF0 b=8'h20 -> next cycle out_valid=1, z=8'h10, cout=1, zero=0, neg=0.
2. Sub a=8'h05 b=8'h07 -> z=8'hFE, cout=1, neg=1; sub-dec 01000 a=8'h07 b=8'h06 -> z=8'h00, cout=0, zero=1.
3. MUL a=8'hFF b=8'hFF -> in_ready low 8 cycles; out_valid rises on 8th edge after accept; {z_hi,z}=16'hFE01, cout=0, neg=1.
4. Backpressure: out_ready=0, issue A|B 8'h0F/8'hF0 -> z=8'hFF held; in_ready=0; a second in_valid is not accepted for 5 cycles. Raise out_ready -> back-to-back ops then complete 1/cycle.
5. Shift: SHL a=8'h81 b=1 -> z=8'h02, cout=1. SHR a=8'h01 b=3 -> z=8'h00, cout=0, zero=1.
6. Reset mid-MUL (rst_n low on 3rd BUSY cycle) -> next edge out_valid=0, in_ready=1, z=z_hi=0, all flags 0. Undefined opcode 11111 -> z=0, cout=0, zero=1.
